// File: rtl/cpu_pkg.sv
// Shared VeriRISC definitions: opcode and phase encodings plus the default opcode width.
package cpu_pkg;

    localparam int unsigned OPC_W_DEF = 3;

    typedef enum logic [2:0] {
        OpHlt = 3'd0,
        OpSkz = 3'd1,
        OpAdd = 3'd2,
        OpAnd = 3'd3,
        OpXor = 3'd4,
        OpLda = 3'd5,
        OpSto = 3'd6,
        OpJmp = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        PhInstAddr  = 3'd0,
        PhInstFetch = 3'd1,
        PhInstLoad  = 3'd2,
        PhIdle      = 3'd3,
        PhOpAddr    = 3'd4,
        PhOpFetch   = 3'd5,
        PhAluOp     = 3'd6,
        PhStore     = 3'd7
    } phase_e;

endpackage

// File: rtl/cpu_controller_if.sv
// Controller-to-datapath bundle: opcode/zero flow in, control strobes flow out.
interface cpu_controller_if #(
    parameter int unsigned OPC_W = cpu_pkg::OPC_W_DEF
);

    logic [OPC_W-1:0] opcode;
    logic             zero;
    logic             sel;
    logic             rd;
    logic             ld_ir;
    logic             inc_pc;
    logic             halt;
    logic             ld_pc;
    logic             data_e;
    logic             ld_ac;
    logic             wr;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

endinterface

// File: rtl/phase_counter.sv
// 3-bit wrapping phase counter; hold freezes it (used while the processor is halted).
module phase_counter
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    output phase_e count
);

    phase_e count_d, count_q;

    // Next phase: advance by one and wrap STORE -> INST_ADDR, unless held.
    always_comb begin
        count_d = count_q;
        if (!hold) begin
            count_d = phase_e'(3'(count_q + 3'd1));
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= PhInstAddr;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_controller.sv
// VeriRISC eight-phase instruction sequencer driving all datapath control strobes.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned OPC_W = OPC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_controller_if.master bus
);

    phase_e           phase;
    logic             halted_d, halted_q;
    logic [OPC_W-1:0] opc;
    logic             is_hlt, is_skz, is_sto, is_jmp, is_aluop;

    assign opc      = bus.opcode;
    assign is_hlt   = (opc == OPC_W'(OpHlt));
    assign is_skz   = (opc == OPC_W'(OpSkz));
    assign is_sto   = (opc == OPC_W'(OpSto));
    assign is_jmp   = (opc == OPC_W'(OpJmp));
    assign is_aluop = (opc == OPC_W'(OpAdd)) || (opc == OPC_W'(OpAnd)) ||
                      (opc == OPC_W'(OpXor)) || (opc == OPC_W'(OpLda));

    phase_counter u_phase_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (halted_q),
        .count (phase)
    );

    // Halted flag: set leaving OP_ADDR on a HLT; sticky until reset.
    always_comb begin
        halted_d = halted_q;
        if (phase == PhOpAddr && is_hlt) begin
            halted_d = 1'b1;
        end
    end

    // Halted flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Strobe decode from phase, halted flag, opcode and zero; no added latency.
    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.halt   = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.data_e = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        if (halted_q) begin
            bus.halt = 1'b1;
        end else begin
            unique case (phase)
                PhInstAddr: begin
                    bus.sel = 1'b1;
                end
                PhInstFetch: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                PhInstLoad, PhIdle: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                PhOpAddr: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = is_hlt;
                end
                PhOpFetch: begin
                    bus.rd = is_aluop;
                end
                PhAluOp: begin
                    bus.rd     = is_aluop;
                    // Second PC increment skips the next instruction when ACC is zero.
                    bus.inc_pc = is_skz & bus.zero;
                    bus.ld_pc  = is_jmp;
                    // Drive data one cycle early so the bus is set up before wr.
                    bus.data_e = is_sto;
                end
                PhStore: begin
                    bus.rd     = is_aluop;
                    bus.ld_ac  = is_aluop;
                    bus.ld_pc  = is_jmp;
                    bus.data_e = is_sto;
                    bus.wr     = is_sto;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected strobes/phase queued at stimulus time.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cpu_controller_if #(.OPC_W(OPC_W_DEF)) bus_if ();

    cpu_controller #(.OPC_W(OPC_W_DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Strobe vector order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
    typedef struct packed {
        logic [8:0] outs;
        logic [2:0] ph;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_phase  = 0;
    bit   m_halted = 1'b0;

    // Reference strobes for one cycle, written directly from the phase table.
    function automatic logic [8:0] model(int ph, bit hl, logic [2:0] op, logic z);
        logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
        bit   alu;
        {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr} = 9'b0;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (hl) begin
            halt = 1'b1;
        end else begin
            case (ph)
                0: sel = 1'b1;
                1: begin sel = 1'b1; rd = 1'b1; end
                2, 3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                4: begin inc_pc = 1'b1; halt = (op == 3'd0); end
                5: rd = alu;
                6: begin
                    rd = alu; inc_pc = (op == 3'd1) && z;
                    ld_pc = (op == 3'd7); data_e = (op == 3'd6);
                end
                default: begin
                    rd = alu; ld_ac = alu; ld_pc = (op == 3'd7);
                    data_e = (op == 3'd6); wr = (op == 3'd6);
                end
            endcase
        end
        return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    endfunction

    function automatic logic [8:0] observed();
        return {bus_if.sel, bus_if.rd, bus_if.ld_ir, bus_if.inc_pc, bus_if.halt,
                bus_if.ld_pc, bus_if.data_e, bus_if.ld_ac, bus_if.wr};
    endfunction

    // Queue n cycles of expectations for the current opcode/zero and advance the model.
    task automatic push_expected(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.outs = model(m_phase, m_halted, bus_if.opcode, bus_if.zero);
            e.ph   = 3'(m_phase);
            sb_q.push_back(e);
            if (!m_halted) begin
                if (m_phase == 4 && bus_if.opcode == 3'd0) m_halted = 1'b1;
                m_phase = (m_phase + 1) % 8;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        bus_if.opcode = 3'd5;
        bus_if.zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (observed() !== 9'b1_0000_0000) begin
            n_errors++;
            $display("FAIL reset_outs: got %b, expected %b", observed(), 9'b1_0000_0000);
        end
        n_checks++;
        if (dut.phase !== PhInstAddr) begin
            n_errors++;
            $display("FAIL reset_phase: got %0d, expected 0", dut.phase);
        end
        rst_n = 1'b1;
        m_phase = 0;
        m_halted = 1'b0;
        push_expected(8);
        for (int i = 0; i < 8; i++) begin
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL reset_seq c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lda();
        exp_t e;
        int   rd_cnt = 0;
        bus_if.opcode = 3'd5;
        bus_if.zero = 1'b0;
        push_expected(8);
        for (int i = 0; i < 8; i++) begin
            #1;
            e = sb_q.pop_front();
            rd_cnt += int'(bus_if.rd);
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL lda c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
        n_checks++;
        if (rd_cnt != 6) begin
            n_errors++;
            $display("FAIL lda_rd_count: got %0d, expected 6", rd_cnt);
        end
    endtask

    task automatic test_sto();
        exp_t e;
        int   wr_cnt = 0;
        int   de_cnt = 0;
        bus_if.opcode = 3'd6;
        bus_if.zero = 1'b0;
        push_expected(8);
        for (int i = 0; i < 8; i++) begin
            #1;
            e = sb_q.pop_front();
            wr_cnt += int'(bus_if.wr);
            de_cnt += int'(bus_if.data_e);
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL sto c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
        n_checks++;
        if (wr_cnt != 1 || de_cnt != 2) begin
            n_errors++;
            $display("FAIL sto_counts: got wr=%0d data_e=%0d, expected wr=1 data_e=2",
                     wr_cnt, de_cnt);
        end
    endtask

    task automatic test_skz();
        exp_t e;
        int   inc_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            inc_cnt = 0;
            bus_if.opcode = 3'd1;
            bus_if.zero = (pass == 0);
            push_expected(8);
            for (int i = 0; i < 8; i++) begin
                #1;
                e = sb_q.pop_front();
                inc_cnt += int'(bus_if.inc_pc);
                n_checks++;
                if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                    n_errors++;
                    $display("FAIL skz z%0d c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                             bus_if.zero, i, observed(), dut.phase, e.outs, e.ph);
                end
                @(negedge clk);
            end
            n_checks++;
            if (inc_cnt != ((pass == 0) ? 2 : 1)) begin
                n_errors++;
                $display("FAIL skz_inc_count pass%0d: got %0d, expected %0d",
                         pass, inc_cnt, (pass == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_jmp();
        exp_t e;
        bus_if.opcode = 3'd7;
        bus_if.zero = 1'b1;
        push_expected(8);
        for (int i = 0; i < 8; i++) begin
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL jmp c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            bus_if.opcode = 3'($urandom_range(7, 1));
            bus_if.zero = 1'($urandom_range(1, 0));
            push_expected(8);
            for (int i = 0; i < 8; i++) begin
                #1;
                e = sb_q.pop_front();
                n_checks++;
                if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                    n_errors++;
                    $display("FAIL b2b op%0d z%0d c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                             bus_if.opcode, bus_if.zero, i, observed(), dut.phase, e.outs, e.ph);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        bus_if.opcode = 3'd2;
        bus_if.zero = 1'b0;
        push_expected(5);
        for (int i = 0; i < 5; i++) begin
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL abort_pre c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({observed(), dut.phase} !== {9'b1_0000_0000, 3'd0}) begin
            n_errors++;
            $display("FAIL abort_reset: got outs=%b ph=%0d, expected outs=100000000 ph=0",
                     observed(), dut.phase);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        m_phase = 0;
        m_halted = 1'b0;
        push_expected(8);
        for (int i = 0; i < 8; i++) begin
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL abort_post c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        int   halt_cnt = 0;
        bus_if.opcode = 3'd0;
        bus_if.zero = 1'b0;
        push_expected(30);
        for (int i = 0; i < 30; i++) begin
            #1;
            e = sb_q.pop_front();
            halt_cnt += int'(bus_if.halt);
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL halt c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
        n_checks++;
        if (halt_cnt != 26) begin
            n_errors++;
            $display("FAIL halt_count: got %0d, expected 26", halt_cnt);
        end
        // Change opcode while halted; the frozen controller must ignore it.
        bus_if.opcode = 3'd5;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({observed(), dut.phase} !== {9'b1_0000_0000, 3'd0}) begin
            n_errors++;
            $display("FAIL halt_reset: got outs=%b ph=%0d, expected outs=100000000 ph=0",
                     observed(), dut.phase);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = 0;
        m_halted = 1'b0;
        push_expected(8);
        for (int i = 0; i < 8; i++) begin
            #1;
            e = sb_q.pop_front();
            n_checks++;
            if ({observed(), dut.phase} !== {e.outs, e.ph}) begin
                n_errors++;
                $display("FAIL halt_resume c%0d: got outs=%b ph=%0d, expected outs=%b ph=%0d",
                         i, observed(), dut.phase, e.outs, e.ph);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lda();
        test_sto();
        test_skz();
        test_jmp();
        test_back_to_back();
        test_abort();
        test_halt();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
